// File: rtl/disp_arbiter_if.sv
// Requester and display-side signals of the shared seven-segment display arbiter.
// The master drives requests, values and decimal points; the slave returns grants and segment bytes.
interface disp_arbiter_if;
  logic        req0;
  logic [15:0] data0;
  logic [3:0]  dp0;
  logic        req1;
  logic [15:0] data1;
  logic [3:0]  dp1;
  logic        gnt0;
  logic        gnt1;
  logic [7:0]  in3;
  logic [7:0]  in2;
  logic [7:0]  in1;
  logic [7:0]  in0;

  modport master (
    output req0, data0, dp0, req1, data1, dp1,
    input  gnt0, gnt1, in3, in2, in1, in0
  );

  modport slave (
    input  req0, data0, dp0, req1, data1, dp1,
    output gnt0, gnt1, in3, in2, in1, in0
  );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 4-digit display with minimum hold, hex decode and leading-zero blanking.
// Grants are registered; segment bytes follow one cycle later. Requests are levels, with no backpressure.
module disp_arbiter #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 500,
  parameter int LZB        = 1
) (
  input  logic            clk,
  input  logic            reset,
  disp_arbiter_if.slave   bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_owner_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [HW-1:0]   hold_cnt_q;
  logic            tick;
  logic            hold_done;
  logic [31:0]     seg_d, seg_q;
  logic [15:0]     own_data;
  logic [3:0]      own_dp;
  logic [3:0]      blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign hold_done = (hold_cnt_q >= HW'(HOLD_TICKS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_owner_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req0)                  state_d = bus.req1 ? OWN1 : IDLE;
        else if (bus.req1 && hold_done) state_d = OWN1;
      end
      OWN1: begin
        if (!bus.req1)                  state_d = bus.req0 ? OWN0 : IDLE;
        else if (bus.req0 && hold_done) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      tick_cnt_q   <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      // A fresh owner always starts its hold from zero, even on a direct hand-off.
      if (state_d != state_q && state_d != IDLE)
        hold_cnt_q <= '0;
      else if (tick && state_q != IDLE && !hold_done)
        hold_cnt_q <= hold_cnt_q + 1'b1;
      if (state_d == OWN0 && state_q != OWN0) last_owner_q <= 1'b0;
      if (state_d == OWN1 && state_q != OWN1) last_owner_q <= 1'b1;
    end
  end

  assign own_data = (state_q == OWN1) ? bus.data1 : bus.data0;
  assign own_dp   = (state_q == OWN1) ? bus.dp1   : bus.dp0;

  always_comb begin
    blank = 4'b0000;
    if (LZB != 0) begin
      blank[3] = (own_data[15:12] == 4'h0);
      blank[2] = blank[3] && (own_data[11:8] == 4'h0);
      blank[1] = blank[2] && (own_data[7:4] == 4'h0);
    end
    seg_d = 32'hFFFF_FFFF;
    if (state_q != IDLE) begin
      for (int i = 0; i < 4; i++) begin
        seg_d[8*i +: 8] = {~own_dp[i], blank[i] ? 7'h7F : hex7(own_data[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) seg_q <= 32'hFFFF_FFFF;
    else        seg_q <= seg_d;
  end

  assign bus.gnt0 = (state_q == OWN0);
  assign bus.gnt1 = (state_q == OWN1);
  assign bus.in3  = seg_q[31:24];
  assign bus.in2  = seg_q[23:16];
  assign bus.in1  = seg_q[15:8];
  assign bus.in0  = seg_q[7:0];
endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Schedules ownership of the shared 4-digit seven-segment display between two requesters (e.g. a value monitor and an error reporter).
- Arbitrates round-robin with a minimum hold time, decodes the owner's 16-bit hex value into four segment bytes, and applies optional leading-zero blanking.
- Outputs feed the digit inputs of the display multiplexer directly: in3 is the leftmost digit, in0 the rightmost.

Parameters:
- TICK_DIV, 50000, clock cycles per hold-time tick (1 ms at 50 MHz).
- HOLD_TICKS, 500, minimum ticks an owner keeps the display before it can be preempted.
- LZB, 1, 1 = blank leading zero digits; 0 = show all four digits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req0  in  1  requester 0 wants the display (level)
- data0  in  16  requester 0 hex value, nibble 3 is the leftmost digit
- dp0  in  4  requester 0 decimal points, 1 = lit, bit i belongs to digit i
- req1  in  1  requester 1 wants the display
- data1  in  16  requester 1 hex value
- dp1  in  4  requester 1 decimal points
- gnt0  out  1  requester 0 owns the display
- gnt1  out  1  requester 1 owns the display
- in3, in2, in1, in0  out  8  segment bytes {dp,g,f,e,d,c,b,a}, active-low (0 = lit)

Behaviour:
- Reset (reset=0 at posedge clk): state IDLE, gnt0=gnt1=0, last_owner=1 (so requester 0 wins first), tick and hold counters 0, all in* = 8'hFF (blank).
- Tick generator:
  - Free-running counter 0..TICK_DIV-1.
  - tick is a 1-cycle pulse when the count is TICK_DIV-1.
  - Wraps to 0.
- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0); gnt1 = (state==OWN1). Grants are registered and never both 1.
- IDLE:
  - Only req0 → OWN0. Only req1 → OWN1.
  - Both requesting → the one that is not last_owner.
  - Neither → stay.
- OWNx:
  - reqx=0 → release immediately. Next state is OWNy if reqy, else IDLE. Hold is ignored on release.
  - reqx=1 and reqy=1 and hold_cnt ≥ HOLD_TICKS → OWNy (preemption).
  - Otherwise stay.
- Hold counter:
  - Cleared on every transition into OWN0/OWN1.
  - Increments on tick while owning.
  - Saturates at HOLD_TICKS; no wrap.
- last_owner is updated on every entry to OWNx.
- Display path (registered, 1-cycle latency after the grant/data sample):
  - Owned: each digit i = hex decode of owner data[4i+3:4i], with bit 7 = ~dp[i].
  - IDLE: all 8'hFF.
  - Data and dp are sampled live every cycle from the current owner, so value changes appear one cycle later.
- Hex decode, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero blanking (LZB=1):
  - Digits 3..1 are blanked (segments 7'h7F) while they and all digits to their left are 0.
  - Digit 0 is never blanked.
  - The dp bit is still honoured on a blanked digit.
- Grant switch: gnt changes at the clock edge of the transition, and the new owner's bytes appear on the following edge. There is no blank gap.
- Reset mid-ownership: the next edge forces IDLE and blank outputs. The in-progress hold count is discarded.

Test Plan:
- Reset with req0=req1=1 → gnt0=gnt1=0, in*=FF. Release reset → gnt0=1 next edge, gnt1=0.
- req0=1, data0=16'h12AF, dp0=4'b0001 (TICK_DIV=4, HOLD_TICKS=3) → one cycle after gnt0: in3=F9, in2=A4, in1=88, in0=0E.
- LZB=1, owner data=16'h0007, dp=0 → in3=in2=in1=FF, in0=F8. Data=16'h0000 → in0=C0, others FF.
- Owner 0 holding, req1 asserted at hold_cnt=1 (TICK_DIV=4, HOLD_TICKS=3) → gnt0 stays until hold_cnt reaches 3, then gnt1=1, gnt0=0 on the same edge, and in* shows data1 one cycle later.
- Owner 1 drops req1 with hold_cnt=0 and req0=0 → IDLE next edge, in*=FF one edge after. If req0=1 instead → gnt0 immediately.
- Both requesting from IDLE after last_owner=0 → gnt1 granted. Assert reset mid-ownership → IDLE and all FF on the next edge, with no leftover hold.
